// File: rtl/block_loader.sv
// rtl/block_loader.sv - word-serial 512-bit block capture and hand-off to the SHA-1 core (optional error flag: BLOCK_LOADER_ERR_EN)
module block_loader (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load_i,
    input  logic [31:0]        data_i,
    input  logic               start_i,
    input  logic               core_ready_i,
    input  logic               core_done_i,
    output logic [15:0][31:0]  block_o,
    output logic               block_valid_o,
    output logic               out_valid_o,
    output logic [4:0]         word_cnt_o,
    output logic               err_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FILL  = 3'd1;
    localparam logic [2:0] S_FULL  = 3'd2;
    localparam logic [2:0] S_ISSUE = 3'd3;
    localparam logic [2:0] S_BUSY  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic [4:0] cnt;
    logic       accepting;
    logic       word_wr;
    logic [3:0] wr_idx;

    // Words are only accepted while the block is still being assembled
    assign accepting = (state == S_IDLE) || (state == S_FILL);
    assign word_wr   = load_i && accepting;
    // Words arrive highest index first, so the write slot counts down from 15
    assign wr_idx    = 4'd15 - cnt[3:0];

    // Next-state decode; every unlisted input in a state is ignored
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (load_i) state_nxt = S_FILL;
            S_FILL:  if (load_i && (cnt == 5'd15)) state_nxt = S_FULL;
            S_FULL:  if (start_i) state_nxt = S_ISSUE;
            S_ISSUE: if (core_ready_i) state_nxt = S_BUSY;
            S_BUSY:  if (core_done_i) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Block register and word count; the count saturates at 16 and clears on DONE
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            block_o <= '0;
            cnt     <= '0;
        end else if (word_wr) begin
            block_o[wr_idx] <= data_i;
            if (cnt != 5'd16) cnt <= cnt + 5'd1;
        end else if (state == S_DONE) begin
            cnt <= '0;
        end
    end

    assign word_cnt_o    = cnt;
    assign block_valid_o = (state == S_ISSUE);
    assign out_valid_o   = (state == S_DONE);

`ifdef BLOCK_LOADER_ERR_EN
    logic err_q;
    logic err_set;

    // Protocol violations: early start, load after the block is full, stray done
    always_comb begin
        err_set = (start_i && accepting)
               || (load_i && !accepting)
               || (core_done_i && (state != S_BUSY));
    end

    // Sticky error; a new violation outranks the clear from the first word of a block
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)                           err_q <= 1'b0;
        else if (err_set)                     err_q <= 1'b1;
        else if (load_i && state == S_IDLE)   err_q <= 1'b0;
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_block_loader.sv
// tb/tb_block_loader.sv - directed self-checking bench for block_loader
module tb_block_loader;

`ifdef BLOCK_LOADER_ERR_EN
    localparam logic [31:0] ERR_EXP = 32'd1;
`else
    localparam logic [31:0] ERR_EXP = 32'd0;
`endif

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b0;
    logic              load_i = 1'b0;
    logic [31:0]       data_i = '0;
    logic              start_i = 1'b0;
    logic              core_ready_i = 1'b0;
    logic              core_done_i = 1'b0;
    logic [15:0][31:0] block_o;
    logic              block_valid_o;
    logic              out_valid_o;
    logic [4:0]        word_cnt_o;
    logic              err_o;

    int n_checks = 0;
    int n_fail   = 0;
    int valid_cycles;

    block_loader dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .load_i        (load_i),
        .data_i        (data_i),
        .start_i       (start_i),
        .core_ready_i  (core_ready_i),
        .core_done_i   (core_done_i),
        .block_o       (block_o),
        .block_valid_o (block_valid_o),
        .out_valid_o   (out_valid_o),
        .word_cnt_o    (word_cnt_o),
        .err_o         (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic load_word(input logic [31:0] d);
        load_i = 1'b1;
        data_i = d;
        tick();
        load_i = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) tick();
        check("rst_cnt",   {27'd0, word_cnt_o}, 32'd0);
        check("rst_valid", {31'd0, block_valid_o}, 32'd0);
        check("rst_out",   {31'd0, out_valid_o}, 32'd0);
        check("rst_err",   {31'd0, err_o}, 32'd0);
        check("rst_blk15", block_o[15], 32'd0);
        rst_i = 1'b1;
        tick();

        // Normal block: words 15..0 carry their own index
        for (int i = 0; i < 16; i++) begin
            load_word(32'(15 - i));
            if (i == 0) check("norm_cnt1", {27'd0, word_cnt_o}, 32'd1);
        end
        check("norm_cnt16", {27'd0, word_cnt_o}, 32'd16);
        for (int k = 0; k < 16; k++) check($sformatf("norm_blk%0d", k), block_o[k], 32'(k));
        check("norm_full_valid", {31'd0, block_valid_o}, 32'd0);
        core_ready_i = 1'b1;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        valid_cycles = 0;
        if (block_valid_o) valid_cycles++;
        tick();
        if (block_valid_o) valid_cycles++;
        check("norm_valid_cycles", 32'(valid_cycles), 32'd1);
        tick();
        tick();
        core_done_i = 1'b1;
        tick();
        core_done_i = 1'b0;
        core_ready_i = 1'b0;
        check("norm_out_pulse", {31'd0, out_valid_o}, 32'd1);
        tick();
        check("norm_out_low", {31'd0, out_valid_o}, 32'd0);
        check("norm_cnt0", {27'd0, word_cnt_o}, 32'd0);
        check("norm_err", {31'd0, err_o}, 32'd0);

        // Gapped loads with ready stalled in ISSUE
        for (int i = 0; i < 16; i++) begin
            load_word(32'h1000_0000 + 32'(i));
            repeat (i % 3 + 1) tick();
        end
        check("gap_cnt16", {27'd0, word_cnt_o}, 32'd16);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        valid_cycles = 0;
        if (block_valid_o) valid_cycles++;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (block_valid_o) valid_cycles++;
            check("gap_blk0_stable", block_o[0], 32'h1000_000F);
            check("gap_blk15_stable", block_o[15], 32'h1000_0000);
        end
        core_ready_i = 1'b1;
        tick();
        core_ready_i = 1'b0;
        if (block_valid_o) valid_cycles++;
        check("gap_valid_cycles", 32'(valid_cycles), 32'd6);
        core_done_i = 1'b1;
        tick();
        core_done_i = 1'b0;
        check("gap_out_pulse", {31'd0, out_valid_o}, 32'd1);
        tick();

        // Early start after ten words
        for (int i = 0; i < 10; i++) load_word(32'h2000_0000 + 32'(i));
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("early_valid", {31'd0, block_valid_o}, 32'd0);
        check("early_cnt", {27'd0, word_cnt_o}, 32'd10);
        check("early_err", {31'd0, err_o}, ERR_EXP);
        for (int i = 10; i < 16; i++) load_word(32'h2000_0000 + 32'(i));
        check("early_cnt16", {27'd0, word_cnt_o}, 32'd16);
        start_i = 1'b1;
        core_ready_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("early_issue", {31'd0, block_valid_o}, 32'd1);
        tick();
        core_ready_i = 1'b0;
        core_done_i = 1'b1;
        tick();
        core_done_i = 1'b0;
        check("early_out", {31'd0, out_valid_o}, 32'd1);
        check("early_blk6", block_o[6], 32'h2000_0009);
        tick();

        // Overrun: seventeenth word is dropped
        for (int i = 0; i < 17; i++) load_word(32'hA5A5_0000 + 32'(i));
        check("ovr_blk0", block_o[0], 32'hA5A5_000F);
        check("ovr_blk15", block_o[15], 32'hA5A5_0000);
        check("ovr_cnt", {27'd0, word_cnt_o}, 32'd16);
        check("ovr_err", {31'd0, err_o}, ERR_EXP);

        // Reset mid-fill, asserted between clock edges
        rst_i = 1'b0;
        #2;
        check("rst1_blk0", block_o[0], 32'd0);
        check("rst1_err", {31'd0, err_o}, 32'd0);
        tick();
        rst_i = 1'b1;
        tick();
        for (int i = 0; i < 7; i++) load_word(32'hB000_0000 + 32'(i));
        check("mid_cnt7", {27'd0, word_cnt_o}, 32'd7);
        #2;
        rst_i = 1'b0;
        #1;
        check("mid_rst_cnt", {27'd0, word_cnt_o}, 32'd0);
        check("mid_rst_blk15", block_o[15], 32'd0);
        check("mid_rst_blk9", block_o[9], 32'd0);
        check("mid_rst_valid", {31'd0, block_valid_o}, 32'd0);
        check("mid_rst_out", {31'd0, out_valid_o}, 32'd0);
        tick();
        rst_i = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            load_word(32'hC000_0000 + 32'(i));
            if (i == 0) begin
                check("fresh_cnt1", {27'd0, word_cnt_o}, 32'd1);
                check("fresh_blk15", block_o[15], 32'hC000_0000);
            end
        end
        check("fresh_cnt16", {27'd0, word_cnt_o}, 32'd16);
        check("fresh_blk0", block_o[0], 32'hC000_000F);

        // Issue, provoke an overrun in BUSY, then load a second block right away
        start_i = 1'b1;
        core_ready_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        core_ready_i = 1'b0;
        load_word(32'hDEAD_BEEF);
        check("b2b_busy_err", {31'd0, err_o}, ERR_EXP);
        check("b2b_busy_blk0", block_o[0], 32'hC000_000F);
        core_done_i = 1'b1;
        tick();
        core_done_i = 1'b0;
        check("b2b_out", {31'd0, out_valid_o}, 32'd1);
        tick();
        for (int i = 0; i < 16; i++) begin
            load_word(32'hD000_0000 + 32'(i));
            if (i == 0) begin
                check("b2b_err_clr", {31'd0, err_o}, 32'd0);
                check("b2b_cnt1", {27'd0, word_cnt_o}, 32'd1);
                check("b2b_keep_blk0", block_o[0], 32'hC000_000F);
            end
        end
        check("b2b_blk15", block_o[15], 32'hD000_0000);
        check("b2b_blk3", block_o[3], 32'hD000_000C);
        check("b2b_blk0", block_o[0], 32'hD000_000F);
        check("b2b_cnt16", {27'd0, word_cnt_o}, 32'd16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
